spi_sram_responder: RTL and testbench
=====================================

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Parameters
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning memory depth is 2**ADDR_BITS bytes.
REQ-002 SHALL have parameter MEM_INIT, default 0, meaning the initial value of every byte in the simulation-start array.

Interface
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_clk  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 spi_cs_n  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  serial data in, MSB first.
REQ-008 spi_miso  output  1  serial data out, MSB first.
REQ-009 spi_miso_oe  output  1  MISO drive enable; 1 only while streaming read data.
REQ-010 wr_pulse  output  1  one-clk pulse per byte committed to memory.
REQ-011 cmd_err  output  1  one-clk pulse when an unsupported opcode is received.
REQ-012 active  output  1  1 while the CS-low transaction is in any state other than IDLE.

Function
REQ-013 spi_clk, spi_cs_n and spi_mosi SHALL each pass a 2-FF synchronizer; SCK edges SHALL be detected from synchronized samples (3-clk pin-to-action latency).
REQ-014 Operating constraint: SCK high and low phases each >= 4 clk periods; CS setup/hold to SCK >= 4 clk.
REQ-015 States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-016 IDLE->CMD on synchronized CS falling; bit counter and shift register cleared.
REQ-017 CMD: shift MOSI on each SCK rise; after 8 bits, 0x02 or 0x03 -> ADDR, any other opcode -> IGNORE and cmd_err pulses one clk.
REQ-018 ADDR: shift 16 bits; address register = received bits [ADDR_BITS-1:0]; upper bits ignored.
REQ-019 After the 16th address bit: WRITE -> WDATA; READ -> RDATA.
REQ-020 RDATA entry: load mem[addr], drive bit7 on spi_miso, assert spi_miso_oe, all within 1 clk of the 16th rising edge being detected.
REQ-021 RDATA: on each SCK fall, shift out the next bit; after the 8th bit's falling edge, increment addr and load/drive the MSB of the next byte.
REQ-022 WDATA: shift MOSI on SCK rise; on each 8th bit, write the byte to mem[addr], pulse wr_pulse, increment addr.
REQ-023 Address increment SHALL wrap modulo 2**ADDR_BITS (e.g. 0xFF -> 0x00 for ADDR_BITS=8).
REQ-024 Sequential streaming: READ/WRITE SHALL continue indefinitely until CS rises.
REQ-025 IGNORE: no memory access, spi_miso_oe=0, until CS rises.
REQ-026 Any state: synchronized CS rising -> IDLE next clk; a partial (<8 bit) write byte SHALL be discarded; spi_miso_oe=0.
REQ-027 When spi_miso_oe=0, spi_miso SHALL be 0.
REQ-028 CS falling and SCK rising detected in the same clk: the CS edge is processed first, and that SCK edge SHALL be shifted as bit 0.
REQ-029 Read-after-write within the same clk to the same byte SHALL return the newly written value.

Reset
REQ-030 rst_n low SHALL force state IDLE, counters 0, addr 0, spi_miso 0, spi_miso_oe 0, wr_pulse 0, cmd_err 0, active 0, synchronizers to idle levels (spi_clk 0, spi_cs_n 1).
REQ-031 Memory array SHALL NOT be reset; contents survive rst_n.
REQ-032 Reset asserted mid-transaction SHALL abort it; after release the block waits for a fresh CS falling edge.

Verification
REQ-033 Write 0x02, addr 0x0010, data 0xDE 0xAD 0xBE 0xEF, then read 0x03, addr 0x0010, 32 bits -> MISO 0xDEADBEEF; 4 wr_pulse pulses.
REQ-034 Write at addr 0x00FF, 2 bytes 0x11 0x22 (ADDR_BITS=8) -> mem[0xFF]=0x11, mem[0x00]=0x22; read from 0x00FF returns 0x1122.
REQ-035 Opcode 0x9F -> cmd_err one pulse, spi_miso_oe stays 0, memory unchanged, active=1 until CS rises.
REQ-036 Write 0x02, addr 0x0004, then 5 bits, CS rises -> no wr_pulse, mem[0x04] unchanged, state IDLE.
REQ-037 rst_n pulsed mid-read after 12 data bits -> outputs at reset values; a subsequent read of the same address returns the correct data (memory preserved).
REQ-038 Address 0xAB10 with ADDR_BITS=8 -> accesses byte 0x10 (upper address bits ignored).

Source files
------------

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI mode-0 target backed by a 2**ADDR_BITS byte memory. Opcode 0x02
//   streams writes and 0x03 streams reads, each from a 16-bit address.
//   The address wraps modulo the memory depth. Any other opcode is flagged
//   on cmd_err, and the rest of the transaction is ignored.
//   All SPI pins are sampled into the clk domain through 2-FF synchronizers.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   spi_clk        SPI serial clock (mode 0), asynchronous to clk
//   spi_cs_n       chip select, active-low
//   spi_mosi       serial data in, MSB first
//   spi_miso       serial data out, MSB first (0 whenever not driven)
//   spi_miso_oe    MISO drive enable, high only while streaming read data
//   wr_pulse       one-clk pulse per byte committed to memory
//   cmd_err        one-clk pulse on an unsupported opcode
//   active         high while the transaction FSM is not IDLE
//   dbg_state_o    FSM state for observation (IDLE reads as 0)
module spi_sram_responder #(
    parameter int ADDR_BITS = 8,
    parameter int MEM_INIT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wr_pulse,
    output logic       cmd_err,
    output logic       active,
    output logic [2:0] dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_IGNORE = 3'd5
    } state_e;

    // The memory is deliberately left out of reset so contents survive rst_n.
    logic [7:0] mem_q [DEPTH] = '{default: 8'(MEM_INIT)};

    logic [1:0]           sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                 sck_prev_q, cs_prev_q;
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 is_read_q, is_read_d;
    logic [7:0]           tx_q, tx_d;
    logic                 oe_q, oe_d;
    logic                 wr_pulse_q, wr_pulse_d;
    logic                 cmd_err_q, cmd_err_d;

    logic                 sck_s, cs_s, mosi_s;
    logic                 sck_rise, sck_fall, cs_fall, cs_rise;
    logic [7:0]           shift_in;
    logic [ADDR_BITS-1:0] addr_shift, addr_inc, rd_addr;
    logic                 wr_fire;
    logic [7:0]           rd_data;

    assign sck_s  = sck_sync_q[1];
    assign cs_s   = cs_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    assign shift_in = {shift_q[6:0], mosi_s};
    // Only the low ADDR_BITS of the 16 address bits survive the shift.
    assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
    assign addr_inc   = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Write and read ports are computed outside the FSM block so that the
    // write-to-read bypass does not create a combinational loop through it.
    assign wr_fire = (state_q == S_WDATA) & sck_rise & ~cs_rise & (cnt_q == 4'd7);
    // Reads happen either on entry to RDATA (freshly shifted address) or at
    // each byte boundary while streaming (next address).
    assign rd_addr = (state_q == S_ADDR) ? addr_shift : addr_inc;
    assign rd_data = (wr_fire && addr_q == rd_addr) ? shift_in : mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[addr_q] <= shift_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            tx_q        <= '0;
            oe_q        <= 1'b0;
            wr_pulse_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_clk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            wr_pulse_q  <= wr_pulse_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        tx_d       = tx_q;
        oe_d       = oe_q;
        wr_pulse_d = 1'b0;
        cmd_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    // An SCK rise seen together with the CS fall is bit 0.
                    if (sck_rise) begin
                        shift_d = {7'b0, mosi_s};
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_CMD: begin
                if (sck_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (shift_in == 8'h02 || shift_in == 8'h03) begin
                            state_d   = S_ADDR;
                            is_read_d = shift_in[0];
                        end else begin
                            state_d   = S_IGNORE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise) begin
                    addr_d = addr_shift;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        if (is_read_q) begin
                            state_d = S_RDATA;
                            tx_d    = rd_data;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (sck_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (wr_fire) begin
                        cnt_d      = '0;
                        wr_pulse_d = 1'b1;
                        addr_d     = addr_inc;
                    end
                end
            end
            S_RDATA: begin
                // cnt counts bits the host has sampled in the current byte. The
                // fall right after the last address bit has cnt==0 and must not
                // shift, otherwise bit 7 would be lost before it is sampled.
                if (sck_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (sck_fall) begin
                    if (cnt_q == 4'd8) begin
                        cnt_d  = '0;
                        addr_d = addr_inc;
                        tx_d   = rd_data;
                    end else if (cnt_q != 4'd0) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            S_IGNORE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CS release aborts whatever is in flight; a partial byte is dropped.
        if (cs_rise) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            oe_d      = 1'b0;
            cmd_err_d = 1'b0;
        end
    end

    assign spi_miso    = oe_q & tx_q[7];
    assign spi_miso_oe = oe_q;
    assign wr_pulse    = wr_pulse_q;
    assign cmd_err     = cmd_err_q;
    assign active      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Testbench for spi_sram_responder: an SPI host driver, a byte-level memory
// model with an expected-byte queue for MISO, and a per-cycle monitor for
// the output pulse and gating rules.
module tb_spi_sram_responder;

    localparam int HALF = 6;  // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, wr_pulse, cmd_err, active;
    logic [2:0] dbg_state;

    spi_sram_responder #(.ADDR_BITS(8), .MEM_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_pulse(wr_pulse), .cmd_err(cmd_err), .active(active),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         err_cnt = 0;
    logic       oe_seen = 1'b0;
    logic       mon_en = 1'b0;
    logic       wr_prev = 1'b0;
    logic       ce_prev = 1'b0;
    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] wbuf [8];
    logic [31:0] word;
    logic [7:0] rx;
    int         wr0, err0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: pulse widths, MISO gating, OE only inside a transaction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_pulse) wr_cnt++;
            if (cmd_err) err_cnt++;
            if (spi_miso_oe) oe_seen = 1'b1;
            if (!spi_miso_oe) check("miso_zero_when_not_driven", {31'b0, spi_miso}, 32'd0);
            check("oe_implies_active", {31'b0, spi_miso_oe & ~active}, 32'd0);
            check("wr_pulse_one_clk", {31'b0, wr_pulse & wr_prev}, 32'd0);
            check("cmd_err_one_clk", {31'b0, cmd_err & ce_prev}, 32'd0);
            wr_prev = wr_pulse;
            ce_prev = cmd_err;
        end
    end

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b1;
        r = spi_miso;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            r[i] = b;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_active", {31'b0, active}, 32'd0);
        check("idle_state", {29'b0, dbg_state}, 32'd0);
        check("idle_oe", {31'b0, spi_miso_oe}, 32'd0);
    endtask

    task automatic do_write(input logic [15:0] addr, input int n);
        logic [7:0] r;
        int w0;
        w0 = wr_cnt;
        cs_begin();
        spi_byte(8'h02, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
        for (int i = 0; i < n; i++) begin
            spi_byte(wbuf[i], r);
            model_mem[8'(addr[7:0] + i)] = wbuf[i];
        end
        cs_end();
        check("write_pulse_count", 32'(wr_cnt - w0), 32'(n));
    endtask

    task automatic do_read(input logic [15:0] addr, input int n, output logic [31:0] w);
        logic [7:0] r;
        int w0;
        w0 = wr_cnt;
        w = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[8'(addr[7:0] + i)]);
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r);
            check("read_byte", {24'b0, r}, {24'b0, exp_q.pop_front()});
            check("read_oe", {31'b0, spi_miso_oe}, 32'd1);
            w = {w[23:0], r};
        end
        cs_end();
        check("read_no_write", 32'(wr_cnt - w0), 32'd0);
    endtask

    initial begin
        logic b;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_miso", {31'b0, spi_miso}, 32'd0);
        check("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
        check("rst_wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
        check("rst_active", {31'b0, active}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Stream write then read back
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
        do_write(16'h0010, 4);
        do_read(16'h0010, 4, word);
        check("read_deadbeef", word, 32'hDEADBEEF);

        // Address wrap 0xFF -> 0x00
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(16'h00FF, 2);
        do_read(16'h00FF, 2, word);
        check("wrap_read_1122", word, 32'h0000_1122);
        do_read(16'h0000, 1, word);
        check("wrap_mem0", word, 32'h22);
        do_read(16'h00FE, 4, word);
        check("wrap_stream_read", word, 32'h0011_2200);

        // Upper address bits are ignored
        wbuf[0] = 8'h5A;
        do_write(16'hAB20, 1);
        do_read(16'h0020, 1, word);
        check("upper_addr_write", word, 32'h5A);
        do_read(16'hAB10, 1, word);
        check("upper_addr_read", word, 32'hDE);

        // Unsupported opcode
        err0 = err_cnt;
        wr0 = wr_cnt;
        oe_seen = 1'b0;
        cs_begin();
        spi_byte(8'h9F, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        check("bad_op_active", {31'b0, active}, 32'd1);
        cs_end();
        check("bad_op_cmd_err", 32'(err_cnt - err0), 32'd1);
        check("bad_op_no_oe", {31'b0, oe_seen}, 32'd0);
        check("bad_op_no_write", 32'(wr_cnt - wr0), 32'd0);
        do_read(16'h0010, 4, word);
        check("bad_op_mem_kept", word, 32'hDEADBEEF);

        // Partial write byte is discarded
        wr0 = wr_cnt;
        cs_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h04, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        cs_end();
        check("partial_no_pulse", 32'(wr_cnt - wr0), 32'd0);
        do_read(16'h0004, 1, word);
        check("partial_mem_kept", word, 32'h00);

        // CS fall and first SCK rise land together: that rise is opcode bit 7
        @(negedge clk);
        spi_mosi = 1'b0;
        spi_cs_n = 1'b0;
        spi_clk  = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
        for (int i = 6; i >= 0; i--) spi_bit(i < 2, b);  // remaining bits of 0x03
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        check("coincident_edge_read", {24'b0, rx}, 32'hDE);
        cs_end();

        // Reset in the middle of a read, after 12 data bits
        cs_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        check("pre_reset_byte", {24'b0, rx}, 32'hDE);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", {31'b0, spi_miso}, 32'd0);
        check("midrst_oe", {31'b0, spi_miso_oe}, 32'd0);
        check("midrst_wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("midrst_cmd_err", {31'b0, cmd_err}, 32'd0);
        check("midrst_active", {31'b0, active}, 32'd0);
        check("midrst_state", {29'b0, dbg_state}, 32'd0);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_idle", {31'b0, active}, 32'd0);
        do_read(16'h0010, 4, word);
        check("post_rst_mem_kept", word, 32'hDEADBEEF);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
